note_sequencer: RTL and testbench

Producer-side partner of the synthesizer's sound-code request handshake. It answers each synthesizer request (data_rq) with a 4-bit sound_code and a data_rd acknowledge. Codes come from a small programmable note table, and each entry repeats for a programmable number of requests. It replaces the switch-driven sound_code/data_rd hookup, so the top level plays a stored melody.

---
 rtl/note_sequencer.sv | 144 ++++++++++++++
 tb/tb_note_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: answers synthesizer data_rq requests with codes from a programmable note table.
// Define SEQ_LOOP_EN to wrap playback forever instead of stopping with done after entry seq_len.
module note_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DUR_W  = 4
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_code,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [ADDR_W-1:0] seq_len,
  input  logic              start,
  input  logic              stop,
  input  logic              data_rq,
  output logic [3:0]        sound_code,
  output logic              data_rd,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_idx
);
  typedef enum logic [1:0] {IDLE, PLAY_WAIT, PLAY_ACK} state_t;
  state_t            r_state;
  logic [3:0]        r_tcode [DEPTH];
  logic [DUR_W-1:0]  r_tdur  [DEPTH];
  logic [ADDR_W-1:0] r_idx;
  logic [DUR_W-1:0]  r_rep;
  logic [3:0]        r_code;
  logic              r_rq_d, r_rq_pend, r_stop_p, r_start_p, r_data_rd, r_busy, r_done;
  logic              w_edge, w_wr_ok, w_stop, w_start;
  logic [ADDR_W-1:0] w_last;
  assign w_edge  = data_rq & ~r_rq_d;
  assign w_wr_ok = wr_en && (32'(wr_addr) < DEPTH);
  assign w_last  = (32'(seq_len) >= DEPTH) ? ADDR_W'(DEPTH - 1) : seq_len;
  assign w_stop  = stop | r_stop_p;
  assign w_start = start | r_start_p;
  assign sound_code = r_code;
  assign data_rd    = r_data_rd;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cur_idx    = r_idx;
  // r_rq_d resets high so a request already held through reset is not taken as a new edge
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_rq_d    <= 1'b1;
      r_rq_pend <= 1'b0;
      r_stop_p  <= 1'b0;
      r_start_p <= 1'b0;
      r_code    <= '0;
      r_data_rd <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= '0;
      r_rep     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tcode[i] <= '0;
        r_tdur[i]  <= '0;
      end
    end else begin
      r_rq_d <= data_rq;
      if (w_wr_ok) begin
        r_tcode[wr_addr] <= wr_code;
        r_tdur[wr_addr]  <= wr_dur;
      end
      if (r_data_rd && !data_rq && r_state != PLAY_ACK) begin
        r_data_rd <= 1'b0;
        r_code    <= '0;
      end
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_state   <= PLAY_WAIT;
            r_busy    <= 1'b1;
            r_idx     <= '0;
            r_rep     <= '0;
            r_done    <= 1'b0;
            r_rq_pend <= r_rq_pend | w_edge;
          end else if (w_edge || r_rq_pend) begin
            r_data_rd <= 1'b1;
            r_code    <= '0;
            r_rq_pend <= 1'b0;
          end
        end
        PLAY_WAIT: begin
          if (stop) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_rq_pend <= r_rq_pend | w_edge;
          end else if (start) begin
            r_idx     <= '0;
            r_rep     <= '0;
            r_done    <= 1'b0;
            r_rq_pend <= r_rq_pend | w_edge;
          end else if (w_edge || r_rq_pend) begin
            r_state   <= PLAY_ACK;
            r_data_rd <= 1'b1;
            r_code    <= r_tcode[r_idx];
            r_rq_pend <= 1'b0;
          end
        end
        PLAY_ACK: begin
          if (data_rq) begin
            r_stop_p  <= w_stop;
            r_start_p <= w_start;
          end else begin
            r_data_rd <= 1'b0;
            r_code    <= '0;
            r_stop_p  <= 1'b0;
            r_start_p <= 1'b0;
            if (w_stop) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (w_start) begin
              r_state <= PLAY_WAIT;
              r_idx   <= '0;
              r_rep   <= '0;
              r_done  <= 1'b0;
            end else begin
              r_state <= PLAY_WAIT;
              if (r_rep < r_tdur[r_idx]) r_rep <= r_rep + 1'b1;
              else begin
                r_rep <= '0;
                if (r_idx < w_last) r_idx <= r_idx + 1'b1;
                else begin
`ifdef SEQ_LOOP_EN
                  r_idx <= '0;
`else
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
`endif
                end
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of the note_sequencer handshake, playback and table control.
module tb_note_sequencer;
  localparam int DEPTH = 12;
  localparam int ADDR_W = 4;
  localparam int DUR_W = 4;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic CLOCK_50 = 1'b0, resetn, wr_en, start, stop, data_rq;
  logic [ADDR_W-1:0] wr_addr, seq_len, cur_idx;
  logic [3:0] wr_code, sound_code;
  logic [DUR_W-1:0] wr_dur;
  logic data_rd, busy, done;
  int total = 0, bad = 0;

  note_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DUR_W(DUR_W)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_code(wr_code), .wr_dur(wr_dur), .seq_len(seq_len), .start(start),
    .stop(stop), .data_rq(data_rq), .sound_code(sound_code), .data_rd(data_rd),
    .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cyc();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hs(input logic [3:0] exp_code, input string tag);
    data_rq = 1'b1;
    cyc();
    chk({tag, "_rd"}, data_rd, 1);
    chk({tag, "_code"}, sound_code, exp_code);
    data_rq = 1'b0;
    cyc();
    chk({tag, "_rd_low"}, data_rd, 0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [3:0] c, input logic [DUR_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_code = c; wr_dur = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int acks;
    logic prev, stable;
    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_code = '0; wr_dur = '0;
    seq_len = '0; start = 1'b0; stop = 1'b0; data_rq = 1'b1;
    #12;
    chk("rst_rd", data_rd, 0);
    chk("rst_code", sound_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    cyc();
    resetn = 1'b1;
    repeat (3) cyc();
    chk("held_through_reset", data_rd, 0);
    data_rq = 1'b0;
    cyc();
    hs(4'd0, "idle_req");

    wr(0, 4'd3, 1);
    wr(1, 4'd9, 0);
    wr(4'd12, 4'd7, 3);
    seq_len = 4'd1;
    pulse_start();
    chk("play_busy", busy, 1);
    chk("play_idx0", cur_idx, 0);
    hs(4'd3, "play1");
    hs(4'd3, "play2");
    chk("play_idx1", cur_idx, 1);
    hs(4'd9, "play3");
    chk("play_done", done, LOOP ? 0 : 1);
    chk("play_busy_end", busy, LOOP ? 1 : 0);
    hs(LOOP ? 4'd3 : 4'd0, "play4");

    pulse_start();
    chk("restart_done_clr", done, 0);
    data_rq = 1'b1;
    acks = 0; prev = 1'b0; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (data_rd && !prev) acks++;
      if (data_rd && sound_code !== 4'd3) stable = 1'b0;
      prev = data_rd;
    end
    chk("held_acks", acks, 1);
    chk("held_stable", stable, 1);
    data_rq = 1'b0;
    cyc();
    chk("held_release", data_rd, 0);

    data_rq = 1'b1;
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_hold_rd", data_rd, 1);
    chk("stop_hold_code", sound_code, 3);
    cyc();
    chk("stop_hold_rd2", data_rd, 1);
    data_rq = 1'b0;
    cyc();
    chk("stop_rd_low", data_rd, 0);
    chk("stop_idle", busy, 0);
    hs(4'd0, "after_stop");
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("ss_idle", busy, 0);
    pulse_start();
    chk("ss_wait_busy", busy, 1);
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("ss_play", busy, 0);

    pulse_start();
    hs(4'd3, "live1");
    hs(4'd3, "live2");
    chk("live_idx", cur_idx, 1);
    wr(1, 4'd5, 0);
    hs(4'd5, "live3");
    chk("live_done", done, LOOP ? 0 : 1);

    wr(4'd11, 4'hA, 0);
    seq_len = 4'd15;
    pulse_start();
    hs(4'd3, "clamp0a");
    hs(4'd3, "clamp0b");
    hs(4'd5, "clamp1");
    for (int i = 2; i < 11; i++) hs(4'd0, "clamp_mid");
    hs(4'hA, "clamp11");
    chk("clamp_done", done, LOOP ? 0 : 1);
    chk("clamp_idx", cur_idx, LOOP ? 0 : 11);

    pulse_start();
    data_rq = 1'b1;
    cyc();
    chk("arst_rd_before", data_rd, 1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_rd", data_rd, 0);
    chk("arst_busy", busy, 0);
    data_rq = 1'b0;
    cyc();
    resetn = 1'b1;
    seq_len = 4'd0;
    cyc();
    pulse_start();
    hs(4'd0, "cleared_table");
    chk("cleared_done", done, LOOP ? 0 : 1);

    wr(0, 4'd6, 0);
    data_rq = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("se_busy", busy, 1);
    chk("se_rd_wait", data_rd, 0);
    cyc();
    chk("se_rd", data_rd, 1);
    chk("se_code", sound_code, 6);
    data_rq = 1'b0;
    cyc();
    chk("se_rd_low", data_rd, 0);
    chk("se_done", done, LOOP ? 0 : 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
